// File: rtl/instr_fetch_sequencer_if.sv
// Memory read port and decoder valid/ready bundle for instr_fetch_sequencer.
interface instr_fetch_sequencer_if #(
   parameter int BYTE       = 8,
   parameter int OPERANDS   = 1,
   parameter int ADDR_WIDTH = 8
);
   logic                         mem_rd;
   logic [ADDR_WIDTH-1:0]        mem_addr;
   logic [BYTE-1:0]              mem_data;
   logic                         start_for_decoder;
   logic                         ready_from_decoder;
   logic [BYTE*(OPERANDS+1)-1:0] data_for_decoder;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_data,
      output start_for_decoder,
      input  ready_from_decoder,
      output data_for_decoder
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_data,
      input  start_for_decoder,
      output ready_from_decoder,
      input  data_for_decoder
   );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetches opcode + OPERANDS bytes and hands the packed word to the decoder.
// Define FETCH_HALT_OPCODE_EN to make HALT_CODE stop fetching.
module instr_fetch_sequencer #(
   parameter int              BYTE       = 8,
   parameter int              OPERANDS   = 1,
   parameter int              ADDR_WIDTH = 8,
   parameter logic [BYTE-1:0] HALT_CODE  = BYTE'(8'hFF)
) (
   input  logic                   clk,
   input  logic                   reset,
   instr_fetch_sequencer_if.master bus,
   output logic                   halted,
   output logic [15:0]            instr_count
);
   localparam int W  = BYTE * (OPERANDS + 1);
   localparam int BW = 2;

   typedef enum logic [1:0] {
      ISSUE,
      CAPTURE,
      SEND,
      HALT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [BW-1:0]         b_q, b_d;
   logic [W-1:0]          buf_q, buf_d;
   logic [W-1:0]          data_q, data_d;
   logic                  start_q, start_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  halt_hit;

`ifdef FETCH_HALT_OPCODE_EN
   assign halt_hit = (b_q == '0) && (bus.mem_data == HALT_CODE);
   assign halted   = (state_q == HALT);
`else
   logic unused_halt_code;
   assign unused_halt_code = ^HALT_CODE;
   assign halt_hit         = 1'b0;
   assign halted           = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      b_d     = b_q;
      buf_d   = buf_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ISSUE: state_d = CAPTURE;
         CAPTURE: begin
            // opcode lands in the top slot, operands fill downwards
            for (int k = 0; k <= OPERANDS; k++) begin
               if (b_q == BW'(k)) begin
                  buf_d[(OPERANDS-k)*BYTE +: BYTE] = bus.mem_data;
               end
            end
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            if (halt_hit) begin
               state_d = HALT;
            end else if (b_q < BW'(OPERANDS)) begin
               b_d     = b_q + BW'(1);
               state_d = ISSUE;
            end else begin
               data_d  = buf_d;
               state_d = SEND;
            end
         end
         SEND: begin
            if (bus.ready_from_decoder) begin
               cnt_d   = cnt_q + 16'd1;
               b_d     = '0;
               state_d = ISSUE;
            end
         end
         HALT: state_d = HALT;
      endcase
      start_d = (state_d == SEND);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ISSUE;
         ptr_q   <= '0;
         b_q     <= '0;
         buf_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         b_q     <= b_d;
         buf_q   <= buf_d;
         data_q  <= data_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
      end
   end

   // masked by reset so the strobe stays low for as long as reset is held
   assign bus.mem_rd            = (state_q == ISSUE) && !reset;
   assign bus.mem_addr          = ptr_q;
   assign bus.start_for_decoder = start_q;
   assign bus.data_for_decoder  = data_q;
   assign instr_count           = cnt_q;
endmodule
